// File: rtl/complex_mult_rr_arbiter_pkg.sv
// Shared complex-multiplier definitions: arbiter FSM state encoding.
package complex_mult_rr_arbiter_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RES = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    ISSUE    = ST_ISSUE,
    WAIT_RES = ST_WAIT_RES,
    RESP     = ST_RESP
  } arb_state_e;

endpackage

// File: rtl/complex_mult_rr_arbiter_rr_pick.sv
// Round-robin winner search starting one past the last grant, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [IW-1:0]      win_o,
  output logic               any_o
);

  logic [IW:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (req_i[cand[IW-1:0]]) begin
        win_o = cand[IW-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/complex_mult_rr_arbiter.sv
// Shares one complex multiplier among NUM_REQ requesters, one transaction in flight.
// Grant -> ISSUE -> WAIT_RES -> RESP; results are passed back untouched.
module complex_mult_rr_arbiter
  import complex_mult_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          sw_rst,
  input  logic [NUM_REQ-1:0]            req_val,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_1_re,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_1_im,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_2_re,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_2_im,
  output logic                          mul_op_val,
  input  logic                          mul_op_ready,
  output logic [DATA_WIDTH-1:0]         mul_op_1_re,
  output logic [DATA_WIDTH-1:0]         mul_op_1_im,
  output logic [DATA_WIDTH-1:0]         mul_op_2_re,
  output logic [DATA_WIDTH-1:0]         mul_op_2_im,
  input  logic                          mul_res_val,
  output logic                          mul_res_ready,
  input  logic [2*DATA_WIDTH-1:0]       mul_result_re,
  input  logic [2*DATA_WIDTH-1:0]       mul_result_im,
  output logic [NUM_REQ-1:0]            rsp_val,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [2*DATA_WIDTH-1:0]       rsp_re,
  output logic [2*DATA_WIDTH-1:0]       rsp_im,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e              state_q;
  logic [IW-1:0]           last_q, gid_q, win;
  logic                    any_req, grant;
  logic [DATA_WIDTH-1:0]   op1_re_q, op1_im_q, op2_re_q, op2_im_q;
  logic [2*DATA_WIDTH-1:0] rsp_re_q, rsp_im_q;

  function automatic logic [DATA_WIDTH-1:0] slice(input logic [NUM_REQ*DATA_WIDTH-1:0] v,
                                                  input logic [IW-1:0] i);
    return DATA_WIDTH'(v >> (int'(i) * DATA_WIDTH));
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_pick (
    .req_i  (req_val),
    .last_i (last_q),
    .win_o  (win),
    .any_o  (any_req)
  );

  assign grant         = (state_q == IDLE) && any_req;
  assign req_ready     = grant ? (NUM_REQ'(1) << win) : '0;
  assign mul_op_val    = (state_q == ISSUE);
  assign mul_res_ready = (state_q == WAIT_RES);
  assign rsp_val       = (state_q == RESP) ? (NUM_REQ'(1) << gid_q) : '0;
  assign busy          = (state_q != IDLE);
  assign grant_id      = gid_q;
  assign mul_op_1_re   = op1_re_q;
  assign mul_op_1_im   = op1_im_q;
  assign mul_op_2_re   = op2_re_q;
  assign mul_op_2_im   = op2_im_q;
  assign rsp_re        = rsp_re_q;
  assign rsp_im        = rsp_im_q;

  // last_q resets to the top index so requester 0 has first priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      last_q   <= IW'(NUM_REQ - 1);
      gid_q    <= '0;
      op1_re_q <= '0;
      op1_im_q <= '0;
      op2_re_q <= '0;
      op2_im_q <= '0;
      rsp_re_q <= '0;
      rsp_im_q <= '0;
    end else if (sw_rst) begin
      state_q  <= IDLE;
      last_q   <= IW'(NUM_REQ - 1);
      gid_q    <= '0;
      op1_re_q <= '0;
      op1_im_q <= '0;
      op2_re_q <= '0;
      op2_im_q <= '0;
      rsp_re_q <= '0;
      rsp_im_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          op1_re_q <= slice(req_op_1_re, win);
          op1_im_q <= slice(req_op_1_im, win);
          op2_re_q <= slice(req_op_2_re, win);
          op2_im_q <= slice(req_op_2_im, win);
          gid_q    <= win;
          last_q   <= win;
          state_q  <= ISSUE;
        end
        ISSUE: if (mul_op_ready) state_q <= WAIT_RES;
        WAIT_RES: if (mul_res_val) begin
          rsp_re_q <= mul_result_re;
          rsp_im_q <= mul_result_im;
          state_q  <= RESP;
        end
        RESP: if (rsp_ready[gid_q]) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_mult_rr_arbiter.sv
// Directed bench for complex_mult_rr_arbiter with 4 requesters of 8-bit operands.
module tb_complex_mult_rr_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;

  logic            clk, rstn, sw_rst;
  logic [N-1:0]    req_val, req_ready;
  logic [N*DW-1:0] req_op_1_re, req_op_1_im, req_op_2_re, req_op_2_im;
  logic            mul_op_val, mul_op_ready;
  logic [DW-1:0]   mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im;
  logic            mul_res_val, mul_res_ready;
  logic [2*DW-1:0] mul_result_re, mul_result_im;
  logic [N-1:0]    rsp_val, rsp_ready;
  logic [2*DW-1:0] rsp_re, rsp_im;
  logic [1:0]      grant_id;
  logic            busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  complex_mult_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
    .req_val(req_val), .req_ready(req_ready),
    .req_op_1_re(req_op_1_re), .req_op_1_im(req_op_1_im),
    .req_op_2_re(req_op_2_re), .req_op_2_im(req_op_2_im),
    .mul_op_val(mul_op_val), .mul_op_ready(mul_op_ready),
    .mul_op_1_re(mul_op_1_re), .mul_op_1_im(mul_op_1_im),
    .mul_op_2_re(mul_op_2_re), .mul_op_2_im(mul_op_2_im),
    .mul_res_val(mul_res_val), .mul_res_ready(mul_res_ready),
    .mul_result_re(mul_result_re), .mul_result_im(mul_result_im),
    .rsp_val(rsp_val), .rsp_ready(rsp_ready),
    .rsp_re(rsp_re), .rsp_im(rsp_im),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ops(input int i, input logic [DW-1:0] a, b, c, d);
    req_op_1_re[i*DW +: DW] = a;
    req_op_1_im[i*DW +: DW] = b;
    req_op_2_re[i*DW +: DW] = c;
    req_op_2_im[i*DW +: DW] = d;
  endtask

  task automatic do_reset;
    rstn = 1'b0; sw_rst = 1'b0; req_val = '0;
    mul_op_ready = 1'b1; mul_res_val = 1'b1; rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    chk_cnt++; if ({busy, mul_op_val, mul_res_ready, rsp_val, req_ready} !== '0)
      $display("FAIL reset_ctrl got %b exp 0", {busy, mul_op_val, mul_res_ready, rsp_val, req_ready});
    else pass_cnt++;
    chk_cnt++; if ({grant_id, mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im, rsp_re, rsp_im} !== '0)
      $display("FAIL reset_data got %h exp 0", {grant_id, mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im, rsp_re, rsp_im});
    else pass_cnt++;
    req_val = 4'b1111;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL reset_priority got %b exp 0001", req_ready);
    else pass_cnt++;
    // Withdrawn before the edge: no grant must happen.
    req_val = 4'b0000;
    @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL drop_req busy got %b exp 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_single;
    do_reset();
    set_ops(0, 8'd3, 8'd4, 8'd1, 8'd2);
    mul_result_re = 16'hFFFB; mul_result_im = 16'h000A;
    req_val = 4'b0001;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_grant got %b exp 0001", req_ready);
    else pass_cnt++;
    @(posedge clk); #1 req_val = '0;
    @(negedge clk);
    chk_cnt++; if ({mul_op_val, mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im} !== {1'b1, 8'd3, 8'd4, 8'd1, 8'd2})
      $display("FAIL single_issue got %h exp 103040102", {mul_op_val, mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({mul_res_ready, rsp_val} !== 5'b1_0000)
      $display("FAIL single_wait got %b exp 10000", {mul_res_ready, rsp_val});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({rsp_val, rsp_re, rsp_im} !== {4'b0001, 16'hFFFB, 16'h000A})
      $display("FAIL single_resp got %b %h %h exp 0001 fffb 000a", rsp_val, rsp_re, rsp_im);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({busy, rsp_val} !== 5'b0)
      $display("FAIL single_done got %b exp 00000", {busy, rsp_val});
    else pass_cnt++;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_oh;
    logic [1:0]   exp_id;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, DW'(i + 1), 8'h00, 8'h00, 8'h00);
    mul_result_re = 16'h0101; mul_result_im = 16'h0202;
    req_val = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_id = 2'(k % N);
      exp_oh = 4'b0001 << (k % N);
      @(negedge clk);
      chk_cnt++; if (req_ready !== exp_oh) $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp_oh);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if ({grant_id, mul_op_1_re} !== {exp_id, DW'(k % N + 1)})
        $display("FAIL rr_issue%0d got %0d/%0d exp %0d/%0d", k, grant_id, mul_op_1_re, exp_id, k % N + 1);
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      chk_cnt++; if (rsp_val !== exp_oh) $display("FAIL rr_rsp%0d got %b exp %b", k, rsp_val, exp_oh);
      else pass_cnt++;
    end
    @(posedge clk); #1 req_val = '0;
  endtask

  task automatic test_op_backpressure;
    do_reset();
    set_ops(2, 8'h55, 8'hAA, 8'h0F, 8'hF0);
    mul_op_ready = 1'b0; mul_res_val = 1'b0;
    req_val = 4'b0100;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL opbp_grant got %b exp 0100", req_ready);
    else pass_cnt++;
    @(posedge clk); #1 req_val = 4'b1011;
    set_ops(2, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (5) begin
      @(negedge clk);
      chk_cnt++; if ({mul_op_val, req_ready, grant_id, mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im} !==
                     {1'b1, 4'b0000, 2'd2, 8'h55, 8'hAA, 8'h0F, 8'hF0})
        $display("FAIL opbp_hold got %b %b %0d %h%h%h%h", mul_op_val, req_ready, grant_id,
                 mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im);
      else pass_cnt++;
    end
    @(posedge clk); #1 mul_op_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if ({mul_op_val, mul_res_ready, req_ready} !== 6'b01_0000)
      $display("FAIL opbp_release got %b exp 010000", {mul_op_val, mul_res_ready, req_ready});
    else pass_cnt++;
  endtask

  task automatic test_rsp_backpressure;
    do_reset();
    mul_result_re = 16'h1234; mul_result_im = 16'hABCD;
    rsp_ready = '0;
    req_val = 4'b1111;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL rspbp_grant got %b exp 0001", req_ready);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1 rsp_ready = 4'b1110;
    mul_result_re = 16'h0000; mul_result_im = 16'h0000;
    repeat (4) begin
      @(negedge clk);
      chk_cnt++; if ({rsp_val, req_ready, rsp_re, rsp_im} !== {4'b0001, 4'b0000, 16'h1234, 16'hABCD})
        $display("FAIL rspbp_hold got %b %b %h %h", rsp_val, req_ready, rsp_re, rsp_im);
      else pass_cnt++;
    end
    @(posedge clk); #1 rsp_ready = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if ({busy, req_ready} !== 5'b0_0010)
      $display("FAIL rspbp_next got %b exp 00010", {busy, req_ready});
    else pass_cnt++;
    @(posedge clk); #1 req_val = '0; rsp_ready = '1;
  endtask

  task automatic test_sw_rst;
    do_reset();
    mul_res_val = 1'b0;
    mul_result_re = 16'h5A5A; mul_result_im = 16'hA5A5;
    req_val = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if ({busy, mul_res_ready} !== 2'b11) $display("FAIL swrst_wait got %b exp 11", {busy, mul_res_ready});
    else pass_cnt++;
    // Result arrives on the same edge as sw_rst; reset must win.
    sw_rst = 1'b1; mul_res_val = 1'b1;
    @(posedge clk); #1 sw_rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({busy, mul_op_val, rsp_val, grant_id, rsp_re, rsp_im} !== '0)
      $display("FAIL swrst_state got %b %b %b %0d %h %h", busy, mul_op_val, rsp_val, grant_id, rsp_re, rsp_im);
    else pass_cnt++;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL swrst_priority got %b exp 0001", req_ready);
    else pass_cnt++;
    @(posedge clk); #1 req_val = '0;
  endtask

  task automatic test_async_reset;
    do_reset();
    mul_result_re = 16'h7777; mul_result_im = 16'h8888;
    rsp_ready = '0;
    req_val = 4'b0001;
    @(negedge clk);
    @(posedge clk); #1 req_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (rsp_val !== 4'b0001) $display("FAIL arst_pre got %b exp 0001", rsp_val);
    else pass_cnt++;
    #2 rstn = 1'b0;
    #1;
    chk_cnt++; if ({busy, mul_op_val, mul_res_ready, rsp_val, req_ready, grant_id, rsp_re, rsp_im} !== '0)
      $display("FAIL arst_now got %b %b %b %b %b %0d %h %h", busy, mul_op_val, mul_res_ready,
               rsp_val, req_ready, grant_id, rsp_re, rsp_im);
    else pass_cnt++;
    @(posedge clk); #1 rstn = 1'b1; rsp_ready = '1;
  endtask

  initial begin
    rstn = 1'b0; sw_rst = 1'b0; req_val = '0;
    req_op_1_re = '0; req_op_1_im = '0; req_op_2_re = '0; req_op_2_im = '0;
    mul_op_ready = 1'b1; mul_res_val = 1'b1; rsp_ready = '1;
    mul_result_re = '0; mul_result_im = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_op_backpressure();
    test_rsp_backpressure();
    test_sw_rst();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
